// File: rtl/alu_result_display.sv
// alu_result_display: binary ALU result -> BCD (sequential double-dabble) -> Basys3 4-digit display.
// Optional feature macro: ALU_DISPLAY_SIGNED_EN (two's-complement input, magnitude + minus sign, N <= 10).
module alu_result_display #(
  parameter int unsigned N            = 5,
  parameter int unsigned REFRESH_BITS = 18
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [N-1:0] i_result,
  output logic [6:0]   o_seg,
  output logic         o_dp,
  output logic [3:0]   o_an,
  output logic [15:0]  o_bcd,
  output logic         o_busy
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    load;
  logic                    shift;
  logic                    commit;
  logic [N-1:0]            r_last;
  logic [N-1:0]            bin_work;
  logic [N-1:0]            conv_val;
  logic [15:0]             bcd_work;
  logic [15:0]             bcd_adj;
  logic [CW-1:0]           iter;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [1:0]              sel;
  logic [3:0]              digit_en;
  logic [3:0]              minus_en;
  logic [3:0]              digit_val;
  logic [3:0]              an_c;
  logic [6:0]              seg_c;

  // Active-low segment pattern (g..a) for one BCD digit; out-of-range nibbles are blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign o_dp = 1'b1;

`ifdef ALU_DISPLAY_SIGNED_EN
  logic neg_work;
  logic neg_disp;

  // Magnitude of the two's-complement input; -2^(N-1) maps to 2^(N-1).
  always_comb begin
    conv_val = i_result;
    if (i_result[N-1]) begin
      conv_val = (~i_result) + N'(1);
    end
  end
`else
  // Unsigned input converts as-is.
  always_comb begin
    conv_val = i_result;
  end
`endif

  // FSM state register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: start on a changed input, N shifts, one commit cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_result != r_last) state_nxt = S_SHIFT;
      S_SHIFT: if (iter == CW'(N - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: datapath strobes.
  always_comb begin
    load   = 1'b0;
    shift  = 1'b0;
    commit = 1'b0;
    case (state)
      S_IDLE:  load   = (i_result != r_last);
      S_SHIFT: shift  = 1'b1;
      S_DONE:  commit = 1'b1;
      default: ;
    endcase
  end

  // Busy flag registered from the next state so it is high exactly in SHIFT and DONE.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_busy <= 1'b0;
    end else begin
      o_busy <= (state_nxt != S_IDLE);
    end
  end

  // Add-3 correction on every working BCD nibble >= 5 before each shift.
  always_comb begin
    bcd_adj = bcd_work;
    for (int k = 0; k < 4; k++) begin
      if (bcd_work[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_work[4*k +: 4] + 4'd3;
      end
    end
  end

  // Double-dabble datapath and atomic commit of the finished BCD value.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_last   <= '0;
      bin_work <= '0;
      bcd_work <= '0;
      iter     <= '0;
      o_bcd    <= '0;
`ifdef ALU_DISPLAY_SIGNED_EN
      neg_work <= 1'b0;
      neg_disp <= 1'b0;
`endif
    end else begin
      if (load) begin
        r_last   <= i_result;
        bin_work <= conv_val;
        bcd_work <= '0;
        iter     <= '0;
`ifdef ALU_DISPLAY_SIGNED_EN
        neg_work <= i_result[N-1];
`endif
      end
      if (shift) begin
        {bcd_work, bin_work} <= {bcd_adj[14:0], bin_work, 1'b0};
        iter                 <= iter + CW'(1);
      end
      if (commit) begin
        o_bcd <= bcd_work;
`ifdef ALU_DISPLAY_SIGNED_EN
        neg_disp <= neg_work;
`endif
      end
    end
  end

  // Free-running refresh counter; its top two bits pick the active digit.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
    end
  end

  assign sel = refresh_cnt[REFRESH_BITS-1 -: 2];

  // Leading-zero blanking: digit k lights only if some digit at or above k is nonzero.
  always_comb begin
    digit_en    = 4'b0001;
    digit_en[1] = |o_bcd[15:4];
    digit_en[2] = |o_bcd[15:8];
    digit_en[3] = |o_bcd[15:12];
  end

`ifdef ALU_DISPLAY_SIGNED_EN
  // Minus sign sits just left of the most significant lit digit.
  always_comb begin
    minus_en = 4'b0000;
    for (int k = 1; k < 4; k++) begin
      minus_en[k] = neg_disp & digit_en[k-1] & ~digit_en[k];
    end
  end
`else
  // No sign in unsigned mode.
  always_comb begin
    minus_en = 4'b0000;
  end
`endif

  // Select the current digit's value and build the anode/segment drive.
  always_comb begin
    case (sel)
      2'd0:    digit_val = o_bcd[3:0];
      2'd1:    digit_val = o_bcd[7:4];
      2'd2:    digit_val = o_bcd[11:8];
      default: digit_val = o_bcd[15:12];
    endcase
    an_c  = 4'b1111;
    seg_c = 7'b1111111;
    if (digit_en[sel]) begin
      an_c[sel] = 1'b0;
      seg_c     = seg_decode(digit_val);
    end else if (minus_en[sel]) begin
      an_c[sel] = 1'b0;
      seg_c     = 7'b0111111;
    end
  end

  // Registered display drive, one cycle behind the digit select.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_an  <= 4'b1111;
      o_seg <= 7'b1111111;
    end else begin
      o_an  <= an_c;
      o_seg <= seg_c;
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
// Self-checking bench for alu_result_display (N=5, REFRESH_BITS=4); honours ALU_DISPLAY_SIGNED_EN.
module tb_alu_result_display;

  localparam int unsigned TN  = 5;
  localparam int unsigned TRB = 4;

  logic          clk;
  logic          rst;
  logic [TN-1:0] result;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic [15:0]   bcd;
  logic          busy;

  int            n_tests;
  int            n_fail;
  int unsigned   ref_cnt;
  int unsigned   last_in;

  logic [6:0] seg_tab [10];
  int unsigned pow10 [4];

  alu_result_display #(.N(TN), .REFRESH_BITS(TRB)) dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_result (result),
    .o_seg    (seg),
    .o_dp     (dp),
    .o_an     (an),
    .o_bcd    (bcd),
    .o_busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Elapsed clock edges since reset release, i.e. the DUT refresh count.
  always @(posedge clk or posedge rst) begin
    if (rst) ref_cnt <= 0;
    else     ref_cnt <= ref_cnt + 1;
  end

  // ---------------- reference model ----------------
  function automatic bit is_neg(input int unsigned v);
`ifdef ALU_DISPLAY_SIGNED_EN
    return v >= (1 << (TN - 1));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned mag_of(input int unsigned v);
    return is_neg(v) ? ((1 << TN) - v) : v;
  endfunction

  function automatic logic [15:0] to_bcd(input int unsigned m);
    logic [15:0] r;
    r[3:0]   = 4'(m % 10);
    r[7:4]   = 4'((m / 10) % 10);
    r[11:8]  = 4'((m / 100) % 10);
    r[15:12] = 4'((m / 1000) % 10);
    return r;
  endfunction

  function automatic int unsigned ndigits(input int unsigned m);
    if (m >= 1000) return 4;
    if (m >= 100)  return 3;
    if (m >= 10)   return 2;
    return 1;
  endfunction

  function automatic logic [3:0] exp_an(input int unsigned m, input bit neg, input int unsigned s);
    logic [3:0] onehot;
    int unsigned nd;
    nd     = ndigits(m);
    onehot = 4'(1) << s;
    if (s < nd || (neg && s == nd)) return ~onehot;
    return 4'b1111;
  endfunction

  function automatic logic [6:0] exp_seg(input int unsigned m, input bit neg, input int unsigned s);
    int unsigned nd;
    nd = ndigits(m);
    if (s < nd) return seg_tab[(m / pow10[s]) % 10];
    if (neg && s == nd) return 7'b0111111;
    return 7'b1111111;
  endfunction

  function automatic int unsigned cur_sel();
    return ((ref_cnt - 1) % (1 << TRB)) / (1 << (TRB - 2));
  endfunction

  // Drive a value (called #1 after an edge) and measure the conversion it triggers.
  task automatic run_conversion(input int unsigned v, output int busy_cycles,
                                output logic [15:0] got_bcd, output bit timed_out);
    result      = TN'(v);
    last_in     = v;
    busy_cycles = 0;
    timed_out   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy) busy_cycles++;
      else if (busy_cycles > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    got_bcd = bcd;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst    = 1'b1;
    result = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || bcd !== 16'h0000 || busy !== 1'b0 || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: an=%b seg=%b bcd=%h busy=%b dp=%b, want 1111 1111111 0000 0 1", an, seg, bcd, busy, dp);
    end
    rst     = 1'b0;
    last_in = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (busy !== 1'b0 || an !== exp_an(0, 1'b0, cur_sel()) || seg !== exp_seg(0, 1'b0, cur_sel())) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d: busy=%b an=%b seg=%b, want 0 %b %b", c, busy, an, seg,
                 exp_an(0, 1'b0, cur_sel()), exp_seg(0, 1'b0, cur_sel()));
      end
    end
  endtask

  task automatic test_convert_31();
    int bc; logic [15:0] b; bit to;
    run_conversion(31, bc, b, to);
    n_tests++;
    if (to || bc != TN + 1) begin
      n_fail++;
      $display("FAIL conv31_busy: busy cycles=%0d timeout=%0b, want %0d", bc, to, TN + 1);
    end
    n_tests++;
    if (b !== to_bcd(mag_of(31))) begin
      n_fail++;
      $display("FAIL conv31_bcd: got %h want %h", b, to_bcd(mag_of(31)));
    end
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (an !== exp_an(mag_of(31), is_neg(31), cur_sel()) || seg !== exp_seg(mag_of(31), is_neg(31), cur_sel())) begin
        n_fail++;
        $display("FAIL conv31_disp c=%0d: an=%b seg=%b, want %b %b", c, an, seg,
                 exp_an(mag_of(31), is_neg(31), cur_sel()), exp_seg(mag_of(31), is_neg(31), cur_sel()));
      end
    end
  endtask

  task automatic test_back_to_back();
    int bc; logic [15:0] b; bit to;
    if (last_in == 31) run_conversion(0, bc, b, to);
    result  = TN'(31);
    last_in = 7;
    @(posedge clk); #1;          // first busy cycle
    @(posedge clk); #1;          // second busy cycle: change input
    result = TN'(7);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!busy) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
    n_tests++;
    if (to || bcd !== to_bcd(mag_of(31))) begin
      n_fail++;
      $display("FAIL b2b_first: bcd=%h timeout=%0b, want %h", bcd, to, to_bcd(mag_of(31)));
    end
    bc = 0; to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy) bc++;
      else if (bc > 0) begin to = 1'b0; break; end
    end
    n_tests++;
    if (to || bc != TN + 1 || bcd !== to_bcd(mag_of(7))) begin
      n_fail++;
      $display("FAIL b2b_second: bcd=%h busy=%0d timeout=%0b, want %h busy %0d", bcd, bc, to, to_bcd(mag_of(7)), TN + 1);
    end
  endtask

  task automatic test_reset_mid();
    int bc; logic [15:0] b; bit to;
    if (last_in == 19) run_conversion(0, bc, b, to);
    result  = TN'(19);
    @(posedge clk); #1;                 // capture edge
    repeat (3) @(posedge clk);          // into the third shift
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || bcd !== 16'h0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: an=%b seg=%b bcd=%h busy=%b, want 1111 1111111 0000 0", an, seg, bcd, busy);
    end
    rst = 1'b0;
    run_conversion(19, bc, b, to);
    n_tests++;
    if (to || bc != TN + 1 || b !== to_bcd(mag_of(19))) begin
      n_fail++;
      $display("FAIL reset_mid_restart: bcd=%h busy=%0d timeout=%0b, want %h", b, bc, to, to_bcd(mag_of(19)));
    end
  endtask

  task automatic test_refresh_sweep();
    int unsigned m; bit ng;
    m  = mag_of(19);
    ng = is_neg(19);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (an !== exp_an(m, ng, cur_sel()) || seg !== exp_seg(m, ng, cur_sel())) begin
        n_fail++;
        $display("FAIL sweep c=%0d: an=%b seg=%b, want %b %b", c, an, seg, exp_an(m, ng, cur_sel()), exp_seg(m, ng, cur_sel()));
      end
    end
  endtask

  task automatic test_random();
    int bc; logic [15:0] b; bit to; int unsigned v;
    for (int t = 0; t < 10; t++) begin
      v = $urandom_range(0, (1 << TN) - 1);
      if (v == last_in) v = (v + 1) % (1 << TN);
      run_conversion(v, bc, b, to);
      n_tests++;
      if (to || bc != TN + 1 || b !== to_bcd(mag_of(v))) begin
        n_fail++;
        $display("FAIL rand v=%0d: bcd=%h busy=%0d timeout=%0b, want %h", v, b, bc, to, to_bcd(mag_of(v)));
      end
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        n_tests++;
        if (an !== exp_an(mag_of(v), is_neg(v), cur_sel()) || seg !== exp_seg(mag_of(v), is_neg(v), cur_sel())) begin
          n_fail++;
          $display("FAIL rand_disp v=%0d c=%0d: an=%b seg=%b, want %b %b", v, c, an, seg,
                   exp_an(mag_of(v), is_neg(v), cur_sel()), exp_seg(mag_of(v), is_neg(v), cur_sel()));
        end
      end
    end
  endtask

`ifdef ALU_DISPLAY_SIGNED_EN
  task automatic test_signed_min();
    int bc; logic [15:0] b; bit to;
    if (last_in == 16) run_conversion(0, bc, b, to);
    run_conversion(16, bc, b, to);
    n_tests++;
    if (to || b !== 16'h0016) begin
      n_fail++;
      $display("FAIL signed_min_bcd: got %h timeout=%0b want 0016", b, to);
    end
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (an !== exp_an(16, 1'b1, cur_sel()) || seg !== exp_seg(16, 1'b1, cur_sel())) begin
        n_fail++;
        $display("FAIL signed_min_disp c=%0d: an=%b seg=%b, want %b %b", c, an, seg,
                 exp_an(16, 1'b1, cur_sel()), exp_seg(16, 1'b1, cur_sel()));
      end
    end
  endtask
`endif

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    pow10   = '{1, 10, 100, 1000};
    n_tests = 0;
    n_fail  = 0;
    last_in = 0;
    test_reset();
    test_convert_31();
    test_back_to_back();
    test_reset_mid();
    test_refresh_sweep();
    test_random();
`ifdef ALU_DISPLAY_SIGNED_EN
    test_signed_min();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
